matmul_loader: RTL and testbench
================================

MATMUL_LOADER -- requirements
Module: matmul_loader

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DWIDTH, 16, element width.
- AWIDTH, 7, BRAM address width.
- BB_MAT_MUL_SIZE, 8, building-block size; also the words loaded per matrix.
- TIMEOUT_CYCLES, 255, maximum RUN cycles before error.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all logic on posedge.
- reset_0, in, 1, asynchronous active-high reset.
- cfg_start, in, 1, one-cycle pulse that begins a load-and-run job.
- in_valid, in, 1, input stream word valid.
- in_ready, out, 1, loader accepts the word this cycle.
- in_data, in, BB_MAT_MUL_SIZE*DWIDTH, one matrix row (128 b).
- addr_pi, out, AWIDTH, BRAM write address to the matrix_multiplication top.
- data_pi, out, BB_MAT_MUL_SIZE*DWIDTH, BRAM write data.
- we_a, out, 1, write enable for the A BRAMs.
- we_b, out, 1, write enable for the B BRAMs.
- enable_writing_to_mem, out, 1, address mux select for the top.
- start_mat_mul_0, out, 1, held high while the core computes.
- done_mat_mul, in, 1, core completion.
- busy, out, 1, high in every state except IDLE.
- job_done, out, 1, one-cycle pulse when the job completes.
- timeout_err, out, 1, sticky error flag; cleared by the next cfg_start.

Function
REQ-003 FSM states: IDLE, LOAD_A, LOAD_B, FLUSH, RUN, DONE.
REQ-004 IDLE: cfg_start -> LOAD_A; word counter = 0; timeout_err cleared. cfg_start in any other state is ignored.
REQ-005 in_ready = 1 only in LOAD_A and LOAD_B. A word transfers when in_valid && in_ready.
REQ-006 Per accepted word: addr_pi = counter in the same cycle, then counter increments.
- LOAD_A -> LOAD_B after word BB_MAT_MUL_SIZE-1; counter resets to 0.
- LOAD_B -> FLUSH after word BB_MAT_MUL_SIZE-1.
REQ-007 The top registers the address twice before it reaches the BRAM. Therefore data_pi and we_a/we_b for a word appear exactly 2 cycles after its addr_pi, via a 2-stage pipeline. Stage-2 we_a is set for LOAD_A words, we_b for LOAD_B words, never both.
REQ-008 enable_writing_to_mem = 1 from LOAD_A entry through FLUSH exit; 0 otherwise.
REQ-009 in_valid gaps stall loading. addr_pi holds its last value, and the pipeline inserts we = 0 bubbles.
REQ-010 FLUSH lasts 3 cycles, which drains the pipeline and the top's registered enable; then -> RUN.
REQ-011 RUN: start_mat_mul_0 = 1. A cycle counter counts from 0.
- done_mat_mul = 1 -> DONE.
- Counter reaches TIMEOUT_CYCLES with no done -> set timeout_err, go to DONE.
REQ-012 DONE: start_mat_mul_0 = 0, job_done = 1 for exactly one cycle, then -> IDLE.
REQ-013 done_mat_mul outside RUN is ignored.
REQ-014 Counter widths: word counter AWIDTH bits; timeout counter 8 bits, with no wrap before the compare.

Reset
REQ-015 reset_0 asserted, at any time including mid-load or mid-run, forces the following:
- State = IDLE.
- All counters and pipeline stages = 0.
- Outputs in_ready, we_a, we_b, enable_writing_to_mem, start_mat_mul_0, busy, job_done, timeout_err = 0.
- addr_pi = 0 and data_pi = 0.
REQ-016 After reset deassertion, no write occurs until a new cfg_start.

Structure
REQ-017 A shared package holds DWIDTH, AWIDTH, BB_MAT_MUL_SIZE, TIMEOUT_CYCLES, and the FSM state encoding.
REQ-018 One sub-module, matmul_loader_wpipe, implements the 2-stage data/we delay line. The FSM and counters stay in matmul_loader.

Verification
REQ-019 Back-to-back load: cfg_start, then 16 words with in_valid held high.
- addr_pi runs 0..7 twice.
- we_a is high for 8 cycles, beginning 2 cycles after the first accept.
- we_b is high for 8 cycles following.
- FLUSH then RUN.
REQ-020 Stalled stream: in_valid low for 3 cycles after word 3.
- addr_pi holds 3.
- Exactly 3 we = 0 bubbles appear.
- Final BRAM contents are unchanged vs REQ-019.
REQ-021 Completion: done_mat_mul asserted on the 40th RUN cycle.
- start_mat_mul_0 drops the next cycle.
- job_done pulses once.
- busy = 0 the cycle after.
REQ-022 Timeout: done_mat_mul never asserted -> timeout_err = 1 after 255 RUN cycles, job_done pulses. The next cfg_start clears timeout_err.
REQ-023 Reset mid-LOAD_B at word 5 -> all outputs 0 immediately (asynchronously). A subsequent full job loads correctly from address 0.
REQ-024 End-to-end with the matrix_multiplication top and 8x8 identity A/B -> core output rows match B.

Source files
------------

// File: rtl/matmul_loader_pkg.sv
// Shared constants and FSM encoding for the matrix-multiply BRAM loader.
// The loader and its interface import everything from here.
package matmul_loader_pkg;

  localparam int DWIDTH          = 16;
  localparam int AWIDTH          = 7;
  localparam int BB_MAT_MUL_SIZE = 8;
  localparam int TIMEOUT_CYCLES  = 255;

  localparam int RUN_CNT_W    = 8;
  localparam int FLUSH_CYCLES = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_FLUSH,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic logic is_loading(state_t s);
    return (s == ST_LOAD_A) || (s == ST_LOAD_B);
  endfunction

endpackage

// File: rtl/matmul_loader_if.sv
// Row stream into the loader: one matrix row per accepted word.
interface matmul_loader_if
  import matmul_loader_pkg::*;
#(
  parameter int ROW_W = DWIDTH * BB_MAT_MUL_SIZE
) ();

  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/matmul_loader_wpipe.sv
// Two-stage delay line for BRAM write data and bank enables, matching the
// two address register stages inside the matrix_multiplication top.
module matmul_loader_wpipe #(
  parameter int ROW_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_we_a,
  input  logic             in_we_b,
  input  logic [ROW_W-1:0] in_data,
  output logic             out_we_a,
  output logic             out_we_b,
  output logic [ROW_W-1:0] out_data
);

  logic             s1_we_a_q, s1_we_a_d;
  logic             s1_we_b_q, s1_we_b_d;
  logic [ROW_W-1:0] s1_data_q, s1_data_d;
  logic             s2_we_a_q, s2_we_a_d;
  logic             s2_we_b_q, s2_we_b_d;
  logic [ROW_W-1:0] s2_data_q, s2_data_d;

  // Data only advances with a real write; bubbles keep the last row.
  always_comb begin
    s1_we_a_d = in_we_a;
    s1_we_b_d = in_we_b;
    s1_data_d = s1_data_q;
    if (in_we_a || in_we_b) begin
      s1_data_d = in_data;
    end

    s2_we_a_d = s1_we_a_q;
    s2_we_b_d = s1_we_b_q;
    s2_data_d = s2_data_q;
    if (s1_we_a_q || s1_we_b_q) begin
      s2_data_d = s1_data_q;
    end
  end

  // NOTE: non-blocking assignments so each stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_we_a_q <= 1'b0;
      s1_we_b_q <= 1'b0;
      s2_we_a_q <= 1'b0;
      s2_we_b_q <= 1'b0;
      // NOTE: data stages are reset as well, so data_pi reads 0 after reset.
      s1_data_q <= '0;
      s2_data_q <= '0;
    end else begin
      s1_we_a_q <= s1_we_a_d;
      s1_we_b_q <= s1_we_b_d;
      s1_data_q <= s1_data_d;
      s2_we_a_q <= s2_we_a_d;
      s2_we_b_q <= s2_we_b_d;
      s2_data_q <= s2_data_d;
    end
  end

  assign out_we_a = s2_we_a_q;
  assign out_we_b = s2_we_b_q;
  assign out_data = s2_data_q;

endmodule

// File: rtl/matmul_loader.sv
// Loads one A and one B building block into the matmul BRAMs, then runs the
// core until it reports done or the run timeout expires.
module matmul_loader #(
  parameter int DWIDTH          = matmul_loader_pkg::DWIDTH,
  parameter int AWIDTH          = matmul_loader_pkg::AWIDTH,
  parameter int BB_MAT_MUL_SIZE = matmul_loader_pkg::BB_MAT_MUL_SIZE,
  parameter int TIMEOUT_CYCLES  = matmul_loader_pkg::TIMEOUT_CYCLES
) (
  input  logic                              clk,
  input  logic                              reset_0,
  input  logic                              cfg_start,
  matmul_loader_if.slave                    in_if,
  output logic [AWIDTH-1:0]                 addr_pi,
  output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] data_pi,
  output logic                              we_a,
  output logic                              we_b,
  output logic                              enable_writing_to_mem,
  output logic                              start_mat_mul_0,
  input  logic                              done_mat_mul,
  output logic                              busy,
  output logic                              job_done,
  output logic                              timeout_err
);

  import matmul_loader_pkg::*;

  localparam int ROW_W = BB_MAT_MUL_SIZE * DWIDTH;
  localparam logic [AWIDTH-1:0]    LAST_WORD  = AWIDTH'(BB_MAT_MUL_SIZE - 1);
  localparam logic [RUN_CNT_W-1:0] RUN_LAST   = RUN_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]           FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  state_t               state_q, state_d;
  logic [AWIDTH-1:0]    word_cnt_q, word_cnt_d;
  logic [AWIDTH-1:0]    last_addr_q, last_addr_d;
  logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [1:0]           flush_cnt_q, flush_cnt_d;
  logic                 timeout_err_q, timeout_err_d;

  logic accept;
  logic last_word;

  assign in_if.in_ready = is_loading(state_q);
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign last_word      = (word_cnt_q == LAST_WORD);

  // Show the live counter on an accept, otherwise hold the last accepted address.
  assign addr_pi = accept ? word_cnt_q : last_addr_q;

  // NOTE: every variable gets a default first, so no branch can infer a latch.
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    last_addr_d   = last_addr_q;
    run_cnt_d     = run_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    timeout_err_d = timeout_err_q;

    if (accept) begin
      last_addr_d = word_cnt_q;
      word_cnt_d  = word_cnt_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d       = ST_LOAD_A;
          word_cnt_d    = '0;
          last_addr_d   = '0;
          timeout_err_d = 1'b0;
        end
      end
      ST_LOAD_A: begin
        if (accept && last_word) begin
          state_d    = ST_LOAD_B;
          word_cnt_d = '0;
        end
      end
      ST_LOAD_B: begin
        if (accept && last_word) begin
          state_d     = ST_FLUSH;
          word_cnt_d  = '0;
          flush_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        // Covers the two write pipeline stages plus the top's registered enable.
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d   = ST_RUN;
          run_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        if (done_mat_mul) begin
          state_d = ST_DONE;
        end else if (run_cnt_q == RUN_LAST) begin
          state_d       = ST_DONE;
          timeout_err_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset_0) begin
    if (reset_0) begin
      state_q       <= ST_IDLE;
      word_cnt_q    <= '0;
      last_addr_q   <= '0;
      run_cnt_q     <= '0;
      flush_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      last_addr_q   <= last_addr_d;
      run_cnt_q     <= run_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  matmul_loader_wpipe #(
    .ROW_W (ROW_W)
  ) u_wpipe (
    .clk      (clk),
    .rst      (reset_0),
    .in_we_a  (accept && (state_q == ST_LOAD_A)),
    .in_we_b  (accept && (state_q == ST_LOAD_B)),
    .in_data  (in_if.in_data),
    .out_we_a (we_a),
    .out_we_b (we_b),
    .out_data (data_pi)
  );

  assign enable_writing_to_mem = is_loading(state_q) || (state_q == ST_FLUSH);
  assign start_mat_mul_0       = (state_q == ST_RUN);
  assign busy                  = (state_q != ST_IDLE);
  assign job_done              = (state_q == ST_DONE);
  assign timeout_err           = timeout_err_q;

endmodule

// File: tb/tb_matmul_loader.sv
// Directed bench for matmul_loader with a BRAM model that applies the
// top's two-cycle address delay before committing writes.
module tb_matmul_loader;
  import matmul_loader_pkg::*;

  localparam int ROW_W = DWIDTH * BB_MAT_MUL_SIZE;
  localparam int DEPTH = 1 << AWIDTH;

  logic              clk = 1'b0;
  logic              reset_0;
  logic              cfg_start;
  logic              done_mat_mul;
  logic [AWIDTH-1:0] addr_pi;
  logic [ROW_W-1:0]  data_pi;
  logic              we_a, we_b;
  logic              enable_writing_to_mem;
  logic              start_mat_mul_0;
  logic              busy, job_done, timeout_err;

  matmul_loader_if #(.ROW_W(ROW_W)) sif ();

  matmul_loader dut (
    .clk                   (clk),
    .reset_0               (reset_0),
    .cfg_start             (cfg_start),
    .in_if                 (sif),
    .addr_pi               (addr_pi),
    .data_pi               (data_pi),
    .we_a                  (we_a),
    .we_b                  (we_b),
    .enable_writing_to_mem (enable_writing_to_mem),
    .start_mat_mul_0       (start_mat_mul_0),
    .done_mat_mul          (done_mat_mul),
    .busy                  (busy),
    .job_done              (job_done),
    .timeout_err           (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // BRAM model: address registered twice, as in the matmul top.
  logic [AWIDTH-1:0] a_d1, a_d2;
  logic [ROW_W-1:0]  mem_a [DEPTH];
  logic [ROW_W-1:0]  mem_b [DEPTH];
  bit                clear_mem = 1'b0;

  always @(posedge clk) begin
    a_d1 <= addr_pi;
    a_d2 <= a_d1;
    if (clear_mem) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      if (we_a) mem_a[a_d2] <= data_pi;
      if (we_b) mem_b[a_d2] <= data_pi;
    end
  end

  function automatic logic [ROW_W-1:0] word_of(input int k);
    logic [ROW_W-1:0] w;
    for (int j = 0; j < BB_MAT_MUL_SIZE; j++) w[j*DWIDTH +: DWIDTH] = DWIDTH'(k * 256 + j * 16 + 5);
    return w;
  endfunction

  function automatic logic [191:0] outs();
    return {sif.in_ready, we_a, we_b, enable_writing_to_mem, start_mat_mul_0,
            busy, job_done, timeout_err, addr_pi, data_pi};
  endfunction

  task automatic clear_bram();
    clear_mem = 1'b1;
    @(posedge clk); #1;
    clear_mem = 1'b0;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_quiet", {we_a, we_b, busy, sif.in_ready, enable_writing_to_mem, start_mat_mul_0}, '0);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_mem();
    for (int i = 0; i < BB_MAT_MUL_SIZE; i++) begin
      check("mem_a", mem_a[i], word_of(i));
      check("mem_b", mem_b[i], word_of(BB_MAT_MUL_SIZE + i));
    end
    check("mem_a_stray", mem_a[BB_MAT_MUL_SIZE], '0);
  endtask

  // Called at posedge+1 in IDLE; returns at the negedge of RUN cycle 1,
  // or right after the async reset check when abort_at >= 0.
  task automatic load_job(input int stall_len, input int abort_at, input bit done_noise);
    int acc = 0;
    int stall_left = stall_len;
    int last = -1;
    bit reached = 1'b0;
    int acc_cyc [16];
    logic [AWIDTH-1:0] addr_log [16];
    logic [63:0] we_a_m = '0, we_b_m = '0, exp_a = '0, exp_b = '0;
    int first_we = -1, last_we = -1, bubbles = 0;

    for (int i = 0; i < 16; i++) begin
      acc_cyc[i]  = -1;
      addr_log[i] = '0;
    end

    cfg_start = 1'b1;
    @(negedge clk);
    check("idle_in_ready", sif.in_ready, 1'b0);
    @(posedge clk); #1;
    cfg_start = 1'b0;

    for (int cyc = 0; cyc < 64; cyc++) begin
      if (acc == 4 && stall_left > 0) begin
        sif.in_valid = 1'b0;
        stall_left--;
      end else begin
        sif.in_valid = (acc < 16);
      end
      sif.in_data  = word_of(acc);
      done_mat_mul = done_noise && (acc < 16);
      if (abort_at >= 0 && acc == abort_at) begin
        #2 reset_0 = 1'b1;
        #1 check("reset_async", outs(), '0);
        return;
      end
      @(negedge clk);
      if (cyc == 0) check("load_entry", {enable_writing_to_mem, busy, timeout_err}, 3'b110);
      if (sif.in_valid && sif.in_ready) begin
        acc_cyc[acc]  = cyc;
        addr_log[acc] = addr_pi;
        acc++;
        if (acc == 16) last = cyc;
      end else if (stall_len > 0 && acc == 4) begin
        check("addr_hold", addr_pi, 7'd3);
      end
      we_a_m[cyc] = we_a;
      we_b_m[cyc] = we_b;
      if (last >= 0 && cyc > last && cyc <= last + 3)
        check("flush", {enable_writing_to_mem, start_mat_mul_0, sif.in_ready}, 3'b100);
      if (last >= 0 && cyc == last + 4) begin
        check("run_entry", {enable_writing_to_mem, start_mat_mul_0, busy, sif.in_ready}, 4'b0110);
        reached = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    sif.in_valid = 1'b0;
    done_mat_mul = 1'b0;
    check("reached_run", reached, 1'b1);

    for (int i = 0; i < 16; i++) begin
      int exp_c = i + ((i >= 4) ? stall_len : 0);
      check("accept_cycle", acc_cyc[i], exp_c);
      check("addr", addr_log[i], i % BB_MAT_MUL_SIZE);
      if (i < 8) exp_a[exp_c + 2] = 1'b1;
      else       exp_b[exp_c + 2] = 1'b1;
    end
    check("we_a_mask", we_a_m, exp_a);
    check("we_b_mask", we_b_m, exp_b);

    for (int c = 0; c < 64; c++) begin
      if (we_a_m[c] || we_b_m[c]) begin
        if (first_we < 0) first_we = c;
        last_we = c;
      end
    end
    for (int c = first_we; c >= 0 && c <= last_we; c++)
      if (!we_a_m[c] && !we_b_m[c]) bubbles++;
    check("bubbles", bubbles, stall_len);
  endtask

  // Starts at the negedge of RUN cycle 1; returns at posedge+1 in IDLE.
  task automatic run_job(input int done_at, input int cfg_at, input int exp_cycles, input bit exp_err);
    int run_cyc = 1;
    bit ended = 1'b0;
    for (int n = 2; n < 600; n++) begin
      @(posedge clk); #1;
      done_mat_mul = (n == done_at);
      cfg_start    = (n == cfg_at);
      @(negedge clk);
      if (!start_mat_mul_0) begin
        ended = 1'b1;
        break;
      end
      run_cyc++;
    end
    done_mat_mul = 1'b0;
    cfg_start    = 1'b0;
    check("run_ended", ended, 1'b1);
    check("run_cycles", run_cyc, exp_cycles);
    check("done_pulse", {job_done, busy, timeout_err}, {1'b1, 1'b1, exp_err});
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_after", {job_done, busy, start_mat_mul_0, enable_writing_to_mem}, 4'b0000);
    @(posedge clk); #1;
  endtask

  initial begin
    reset_0      = 1'b1;
    cfg_start    = 1'b0;
    done_mat_mul = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_data  = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", outs(), '0);
    @(posedge clk); #1;
    reset_0 = 1'b0;

    // Stray valid and done while idle must not start anything.
    sif.in_valid = 1'b1;
    done_mat_mul = 1'b1;
    quiet(4);
    sif.in_valid = 1'b0;
    done_mat_mul = 1'b0;

    // Back-to-back load, completion on RUN cycle 40.
    clear_bram();
    load_job(0, -1, 1'b0);
    run_job(40, 0, 40, 1'b0);
    check_mem();

    // Stall after word 3, done_mat_mul toggled during loading.
    clear_bram();
    load_job(3, -1, 1'b1);
    run_job(40, 0, 40, 1'b0);
    check_mem();

    // Timeout with an ignored cfg_start mid-run; flag cleared by the next job.
    load_job(0, -1, 1'b0);
    run_job(0, 10, TIMEOUT_CYCLES, 1'b1);
    check("timeout_sticky", timeout_err, 1'b1);
    clear_bram();
    load_job(0, -1, 1'b0);
    run_job(40, 0, 40, 1'b0);
    check_mem();

    // Reset during LOAD_B at word 5, then a clean job from address 0.
    load_job(0, 13, 1'b0);
    sif.in_valid = 1'b0;
    @(negedge clk);
    check("reset_held", outs(), '0);
    @(negedge clk);
    reset_0 = 1'b0;
    sif.in_valid = 1'b1;
    quiet(3);
    sif.in_valid = 1'b0;
    clear_bram();
    load_job(0, -1, 1'b0);
    run_job(40, 0, 40, 1'b0);
    check_mem();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
